// File: rtl/m_definitions.sv
// Shared types and constants for the M-extension sequencer.
// Op codes, FSM states, datapath mux selects and operand bundle.
package m_definitions;

    localparam int DIV_STEPS = 32;

    localparam int MUX_ALUOUT_LENGTH = 2;
    localparam logic [MUX_ALUOUT_LENGTH-1:0] MUX_ALUOUT_MULT  = 2'd0;
    localparam logic [MUX_ALUOUT_LENGTH-1:0] MUX_ALUOUT_ADDER = 2'd1;
    localparam logic [MUX_ALUOUT_LENGTH-1:0] MUX_ALUOUT_SUBTR = 2'd2;

    localparam int MUX_DIV_REM_LENGTH = 1;
    localparam logic [MUX_DIV_REM_LENGTH-1:0] MUX_DIV_REM_R = 1'b0;
    localparam logic [MUX_DIV_REM_LENGTH-1:0] MUX_DIV_REM_Z = 1'b1;

    typedef enum logic [3:0] {
        OP_MUL    = 4'd0,
        OP_MULH   = 4'd1,
        OP_MULHSU = 4'd2,
        OP_MULHU  = 4'd3,
        OP_DIV    = 4'd4,
        OP_DIVU   = 4'd5,
        OP_REM    = 4'd6,
        OP_REMU   = 4'd7,
        OP_MADD   = 4'd8,
        OP_MSUB   = 4'd9
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    typedef struct packed {
        logic [32:0] a;
        logic [32:0] b;
        logic [31:0] r;
        logic [31:0] d;
        logic        neg_q;
        logic        neg_r;
        logic        div_zero;
    } fmt_t;

    function automatic logic is_div_op(op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_rem_op(op_e op);
        return op inside {OP_REM, OP_REMU};
    endfunction

    function automatic logic is_high_op(op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_MULHU};
    endfunction

endpackage

// File: rtl/m_operand_fmt.sv
// Operand formatting: sign/zero extension, magnitudes for division,
// result sign flags and zero-divisor detect.
module m_operand_fmt
    import m_definitions::*;
(
    input  op_e         op,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output fmt_t        fmt
);

    logic sgn_a;
    logic sgn_b;
    logic sdiv;
    logic modop;

    // Decode signedness and build the operand bundle
    always_comb begin
        sgn_a = 1'b0;
        sgn_b = 1'b0;
        sdiv  = 1'b0;
        modop = 1'b0;
        unique case (op)
            OP_MULH:        begin sgn_a = 1'b1; sgn_b = 1'b1; end
            OP_MULHSU:      sgn_a = 1'b1;
            OP_DIV, OP_REM: begin
                sgn_a = 1'b1;
                sgn_b = 1'b1;
                sdiv  = 1'b1;
            end
            OP_MADD, OP_MSUB: modop = 1'b1;
            default: ;
        endcase

        fmt.div_zero = (rs2 == 32'd0);
        if (modop) begin
            fmt.a = {17'b0, rs1[15:0]};
            fmt.b = {17'b0, rs2[15:0]};
        end else begin
            fmt.a = {sgn_a & rs1[31], rs1};
            fmt.b = {sgn_b & rs2[31], rs2};
        end
        fmt.r = (sdiv && rs1[31]) ? (~rs1 + 32'd1) : rs1;
        fmt.d = (sdiv && rs2[31]) ? (~rs2 + 32'd1) : rs2;
        fmt.neg_q = sdiv && (rs1[31] ^ rs2[31]) && !fmt.div_zero;
        fmt.neg_r = sdiv && rs1[31];
    end

endmodule

// File: rtl/m_seq_ctrl.sv
// Sequencer for the M-extension datapath: multiply/modular ops in one
// pass, restoring division over DIV_STEPS cycles, sign fix-up, handshake.
module m_seq_ctrl
    import m_definitions::*;
#(
    parameter int DIV_STEPS = m_definitions::DIV_STEPS
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [3:0]                    in_op,
    input  logic [31:0]                   in_rs1,
    input  logic [31:0]                   in_rs2,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [31:0]                   out_result,
    output logic [32:0]                   dp_A,
    output logic [32:0]                   dp_B,
    output logic [31:0]                   dp_R,
    output logic [62:0]                   dp_D,
    output logic [31:0]                   dp_Z,
    output logic [MUX_ALUOUT_LENGTH-1:0]  dp_mux_aluout,
    output logic [MUX_DIV_REM_LENGTH-1:0] dp_mux_div_rem,
    input  logic                          dp_sub_neg,
    input  logic [31:0]                   dp_sub_result,
    input  logic [31:0]                   dp_div_rem,
    input  logic [31:0]                   dp_div_rem_neg,
    input  logic [65:0]                   dp_alu_out
);

    localparam int CW = $clog2(DIV_STEPS);

    state_e        state;
    state_e        state_nx;
    op_e           op_in;
    op_e           op_q;
    fmt_t          fmt;
    logic [CW-1:0] cnt;
    logic          neg_q;
    logic          neg_r;
    logic [31:0]   res_q;
    logic          unused_alu;

    assign op_in      = op_e'(in_op);
    assign out_result = res_q;
    assign unused_alu = ^dp_alu_out[65:64];

    m_operand_fmt u_fmt (
        .op  (op_in),
        .rs1 (in_rs1),
        .rs2 (in_rs2),
        .fmt (fmt)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // Next-state: zero divisor skips iteration and goes via FIX
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: if (in_valid) begin
                if (!is_div_op(op_in))  state_nx = ST_MUL;
                else if (fmt.div_zero)  state_nx = ST_FIX;
                else                    state_nx = ST_DIV;
            end
            ST_MUL: state_nx = ST_DONE;
            ST_DIV: if (cnt == CW'(DIV_STEPS - 1)) state_nx = ST_FIX;
            ST_FIX: state_nx = ST_DONE;
            ST_DONE: if (out_ready) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Handshake flags and remainder/quotient select
    always_comb begin
        in_ready       = (state == ST_IDLE);
        out_valid      = (state == ST_DONE);
        dp_mux_div_rem = MUX_DIV_REM_R;
        if (state == ST_FIX && !is_rem_op(op_q))
            dp_mux_div_rem = MUX_DIV_REM_Z;
    end

    // Operand, iteration and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q          <= OP_MUL;
            dp_A          <= '0;
            dp_B          <= '0;
            dp_R          <= '0;
            dp_D          <= '0;
            dp_Z          <= '0;
            cnt           <= '0;
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
            res_q         <= '0;
            dp_mux_aluout <= MUX_ALUOUT_MULT;
        end else begin
            unique case (state)
                ST_IDLE: if (in_valid) begin
                    op_q  <= op_in;
                    dp_A  <= fmt.a;
                    dp_B  <= fmt.b;
                    cnt   <= '0;
                    neg_q <= fmt.neg_q;
                    neg_r <= fmt.neg_r && !fmt.div_zero;
                    // Zero divisor: preload the required R/Z answers
                    dp_R  <= fmt.div_zero ? in_rs1 : fmt.r;
                    dp_Z  <= fmt.div_zero ? '1 : '0;
                    dp_D  <= {fmt.d, 31'b0};
                    if (op_in == OP_MADD)
                        dp_mux_aluout <= MUX_ALUOUT_ADDER;
                    else if (op_in == OP_MSUB)
                        dp_mux_aluout <= MUX_ALUOUT_SUBTR;
                    else
                        dp_mux_aluout <= MUX_ALUOUT_MULT;
                end
                ST_MUL: begin
                    res_q <= is_high_op(op_q) ? dp_alu_out[63:32]
                                              : dp_alu_out[31:0];
                end
                ST_DIV: begin
                    if (!dp_sub_neg) dp_R <= dp_sub_result;
                    dp_Z <= {dp_Z[30:0], ~dp_sub_neg};
                    dp_D <= dp_D >> 1;
                    cnt  <= cnt + 1'b1;
                end
                ST_FIX: begin
                    if (is_rem_op(op_q) ? neg_r : neg_q)
                        res_q <= dp_div_rem_neg;
                    else
                        res_q <= dp_div_rem;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_m_seq_ctrl.sv
// Testbench for m_seq_ctrl with a behavioural datapath and a
// plain-arithmetic reference model for all ops.
module tb_m_seq_ctrl;
    import m_definitions::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_op = 4'd0;
    logic [31:0] in_rs1 = '0;
    logic [31:0] in_rs2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [32:0] dp_A, dp_B;
    logic [31:0] dp_R, dp_Z;
    logic [62:0] dp_D;
    logic [MUX_ALUOUT_LENGTH-1:0]  dp_mux_aluout;
    logic [MUX_DIV_REM_LENGTH-1:0] dp_mux_div_rem;
    logic        dp_sub_neg;
    logic [31:0] dp_sub_result, dp_div_rem, dp_div_rem_neg;
    logic [65:0] dp_alu_out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    m_seq_ctrl dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result),
        .dp_A(dp_A), .dp_B(dp_B), .dp_R(dp_R), .dp_D(dp_D), .dp_Z(dp_Z),
        .dp_mux_aluout(dp_mux_aluout), .dp_mux_div_rem(dp_mux_div_rem),
        .dp_sub_neg(dp_sub_neg), .dp_sub_result(dp_sub_result),
        .dp_div_rem(dp_div_rem), .dp_div_rem_neg(dp_div_rem_neg),
        .dp_alu_out(dp_alu_out)
    );

    // Behavioural arithmetic datapath
    logic [63:0]        diff;
    logic signed [65:0] sa66, sb66;
    always_comb begin
        diff           = {32'b0, dp_R} - {1'b0, dp_D};
        dp_sub_neg     = diff[63];
        dp_sub_result  = diff[31:0];
        dp_div_rem     = (dp_mux_div_rem == MUX_DIV_REM_Z) ? dp_Z : dp_R;
        dp_div_rem_neg = 32'd0 - dp_div_rem;
        sa66 = $signed({{33{dp_A[32]}}, dp_A});
        sb66 = $signed({{33{dp_B[32]}}, dp_B});
        case (dp_mux_aluout)
            MUX_ALUOUT_ADDER: dp_alu_out = sa66 + sb66;
            MUX_ALUOUT_SUBTR: dp_alu_out = sa66 - sb66;
            default:          dp_alu_out = sa66 * sb66;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(op_e op, logic [31:0] a,
                                               logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        p  = '0;
        case (op)
            OP_MUL:    begin p = ua * ub; return p[31:0]; end
            OP_MULH:   begin p = sa * sb; return p[63:32]; end
            OP_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
            OP_MULHU:  begin p = ua * ub; return p[63:32]; end
            OP_DIV:    begin
                if (b == 0) return 32'hFFFFFFFF;
                p = sa / sb; return p[31:0];
            end
            OP_REM:    begin
                if (b == 0) return a;
                p = sa % sb; return p[31:0];
            end
            OP_DIVU:   begin
                if (b == 0) return 32'hFFFFFFFF;
                p = ua / ub; return p[31:0];
            end
            OP_REMU:   begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
            OP_MADD:   return {16'b0, a[15:0]} + {16'b0, b[15:0]};
            OP_MSUB:   return {16'b0, a[15:0]} - {16'b0, b[15:0]};
            default:   return 32'd0;
        endcase
    endfunction

    function automatic int ref_latency(op_e op, logic [31:0] b);
        if ((op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU}) && b != 0)
            return 34;
        return 2;
    endfunction

    task automatic garbage_in();
        in_valid = 1'($urandom_range(0, 1));
        in_op    = 4'($urandom_range(0, 9));
        in_rs1   = $urandom;
        in_rs2   = $urandom;
    endtask

    task automatic run_op(input op_e op, input logic [31:0] a,
                          input logic [31:0] b, input int hold);
        string       nm;
        int          lat;
        bit          seen;
        logic [31:0] exp;
        nm  = op.name();
        exp = ref_result(op, a, b);
        @(negedge clk);
        check({nm, " in_ready idle"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_op    = op;
        in_rs1   = a;
        in_rs2   = b;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            garbage_in();
            if (out_valid) seen = 1'b1;
        end
        if (!seen) begin
            check({nm, " timeout"}, 64'd0, 64'd1);
            in_valid = 1'b0;
            reset = 1'b1;
            @(posedge clk);
            @(negedge clk);
            reset = 1'b0;
            return;
        end
        check({nm, " result"}, 64'(out_result), 64'(exp));
        check({nm, " latency"}, 64'(lat), 64'(ref_latency(op, b)));
        check({nm, " in_ready busy"}, 64'(in_ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            garbage_in();
            check({nm, " hold valid"}, 64'(out_valid), 64'd1);
            check({nm, " hold result"}, 64'(out_result), 64'(exp));
            check({nm, " hold in_ready"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({nm, " in_ready after"}, 64'(in_ready), 64'd1);
        check({nm, " valid after"}, 64'(out_valid), 64'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFFFFFF;
            3:       return 32'h80000000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst in_ready", 64'(in_ready), 64'd1);
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst out_result", 64'(out_result), 64'd0);
        check("rst dp_A", 64'(dp_A), 64'd0);
        check("rst dp_B", 64'(dp_B), 64'd0);
        check("rst dp_R", 64'(dp_R), 64'd0);
        check("rst dp_D", 64'(dp_D), 64'd0);
        check("rst dp_Z", 64'(dp_Z), 64'd0);
        check("rst mux_aluout", 64'(dp_mux_aluout), 64'(MUX_ALUOUT_MULT));
        check("rst mux_div_rem", 64'(dp_mux_div_rem), 64'(MUX_DIV_REM_R));
        reset = 1'b0;

        run_op(OP_MUL,    32'd7,        32'hFFFFFFFD, 0);
        run_op(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        run_op(OP_MULHSU, 32'hFFFFFFFF, 32'd2,        0);
        run_op(OP_MULH,   32'h80000000, 32'h80000000, 0);
        run_op(OP_DIV,    32'hFFFFFFF9, 32'd2,        0);
        run_op(OP_REM,    32'hFFFFFFF9, 32'd2,        0);
        run_op(OP_DIVU,   32'd100,      32'd7,        0);
        run_op(OP_DIV,    32'h12345678, 32'd0,        0);
        run_op(OP_REM,    32'h12345678, 32'd0,        0);
        run_op(OP_REMU,   32'h87654321, 32'd0,        0);
        run_op(OP_DIV,    32'h80000000, 32'hFFFFFFFF, 0);
        run_op(OP_REM,    32'h80000000, 32'hFFFFFFFF, 0);
        run_op(OP_MADD,   32'hABCDFFFF, 32'h12340002, 0);
        run_op(OP_MSUB,   32'h00000001, 32'h00000003, 0);
        run_op(OP_DIVU,   32'd1000,     32'd33,       5);

        // Reset in the middle of a division
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = OP_DIVU;
        in_rs1   = 32'd1000;
        in_rs2   = 32'd7;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("midrst in_ready", 64'(in_ready), 64'd1);
        check("midrst out_valid", 64'(out_valid), 64'd0);
        check("midrst out_result", 64'(out_result), 64'd0);
        check("midrst dp_R", 64'(dp_R), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midrst no valid", 64'(out_valid), 64'd0);
        run_op(OP_DIVU, 32'd9, 32'd3, 0);

        for (int i = 0; i < 40; i++) begin
            run_op(op_e'($urandom_range(0, 9)), pick_operand(),
                   pick_operand(), int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
